// File: rtl/half_adder_pkg.sv
// Shared defaults and legal bounds for the half_adder block.
// Pure constants: no logic, no latency, no flow control.
package half_adder_pkg;

  localparam int HA_DEF_WIDTH = 1;
  localparam int HA_DEF_CNT_W = 8;
  localparam int HA_MAX_WIDTH = 64;
  localparam int HA_MAX_CNT_W = 32;

endpackage

// File: rtl/half_adder_cell.sv
// One-bit half adder cell: sum = a ^ b, carry = a & b.
// Purely combinational, zero latency, no backpressure.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Lane-parallel half adder with registered copy and saturating carry-cycle counter.
// Combinational outputs zero latency, registered outputs 1 cycle; no backpressure.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_DEF_WIDTH,
  parameter int CNT_W = HA_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic [CNT_W-1:0] carry_cnt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

  // Counts cycles with any lane carrying, not lanes; holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if ((|carry) && (carry_cnt != {CNT_W{1'b1}})) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Directed bench: 4-lane instance driven from a vector table, 1-lane 3-bit-counter
// instance for truth table, latency and saturation; shared reset for pulse checks.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a4, b4, s4, c4, sq4, cq4;
  logic [7:0] cnt4;
  logic       a1, b1, s1, c1, sq1, cq1;
  logic [2:0] cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a4),
    .b         (b4),
    .sum       (s4),
    .carry     (c4),
    .sum_q     (sq4),
    .carry_q   (cq4),
    .carry_cnt (cnt4)
  );

  half_adder #(.WIDTH(1), .CNT_W(3)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a1),
    .b         (b1),
    .sum       (s1),
    .carry     (c1),
    .sum_q     (sq1),
    .carry_q   (cq1),
    .carry_cnt (cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs driven just after a rising edge, checked at the following falling edge:
  // registered fields hold the previous row's results, cnt the count so far.
  typedef struct {
    logic [3:0] a, b, sum, carry, sum_q, carry_q;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[12];

  logic tt_s[4];
  logic tt_c[4];
  logic pv_s[4];

  initial begin
    tbl[0]  = '{4'b1100, 4'b1010, 4'b0110, 4'b1000, 4'b0000, 4'b0000, 8'd0};
    tbl[1]  = '{4'b1100, 4'b1010, 4'b0110, 4'b1000, 4'b0110, 4'b1000, 8'd1};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0110, 4'b1000, 8'd2};
    tbl[3]  = '{4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 8'd3};
    tbl[4]  = '{4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 8'd3};
    tbl[5]  = '{4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 8'd3};
    tbl[6]  = '{4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 8'd3};
    tbl[7]  = '{4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 8'd3};
    tbl[8]  = '{4'b0011, 4'b0110, 4'b0101, 4'b0010, 4'b1111, 4'b0000, 8'd3};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0010, 8'd4};
    tbl[10] = '{4'b1001, 4'b0001, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 8'd4};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 8'd5};

    // {a,b} = 0..3 truth table, and sum_q of the previous step when stepped in order
    tt_s = '{1'b0, 1'b1, 1'b1, 1'b0};
    tt_c = '{1'b0, 1'b0, 1'b0, 1'b1};
    pv_s = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    a4 = '0; b4 = '0; a1 = 1'b0; b1 = 1'b0;

    // Combinational path live in reset; registers and counter stay cleared across edges.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      @(negedge clk);
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      #2;
      chk("rst_sum", 32'(s1), 32'(tt_s[i]));
      chk("rst_carry", 32'(c1), 32'(tt_c[i]));
      #5;
      chk("rst_sum_q", 32'(sq1), 32'd0);
      chk("rst_carry_q", 32'(cq1), 32'd0);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
    end
    chk("rst_sum_q4", 32'(sq4), 32'd0);
    chk("rst_carry_q4", 32'(cq4), 32'd0);
    chk("rst_cnt4", 32'(cnt4), 32'd0);

    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      a4 = tbl[k].a;
      b4 = tbl[k].b;
      @(negedge clk);
      chk($sformatf("v%0d_sum", k), 32'(s4), 32'(tbl[k].sum));
      chk($sformatf("v%0d_carry", k), 32'(c4), 32'(tbl[k].carry));
      chk($sformatf("v%0d_sum_q", k), 32'(sq4), 32'(tbl[k].sum_q));
      chk($sformatf("v%0d_carry_q", k), 32'(cq4), 32'(tbl[k].carry_q));
      chk($sformatf("v%0d_cnt", k), 32'(cnt4), 32'(tbl[k].cnt));
    end

    // Mid-run reset pulse between edges, then normal capture on the first edge after it.
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_sum_q", 32'(sq4), 32'd0);
    chk("pulse_carry_q", 32'(cq4), 32'd0);
    chk("pulse_cnt", 32'(cnt4), 32'd0);
    a4 = 4'b1100;
    b4 = 4'b1010;
    #1;
    chk("pulse_sum", 32'(s4), 32'(4'b0110));
    chk("pulse_carry", 32'(c4), 32'(4'b1000));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_sum_q", 32'(sq4), 32'(4'b0110));
    chk("post_carry_q", 32'(cq4), 32'(4'b1000));
    chk("post_cnt", 32'(cnt4), 32'd1);
    a4 = '0;
    b4 = '0;

    // Truth table with rst_n high; registered outputs lag by exactly one edge.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      #2;
      chk("tt_sum", 32'(s1), 32'(tt_s[i]));
      chk("tt_carry", 32'(c1), 32'(tt_c[i]));
      chk("tt_sum_q", 32'(sq1), 32'(pv_s[i]));
      chk("tt_carry_q", 32'(cq1), 32'd0);
      chk("tt_cnt", 32'(cnt1), 32'd0);
      @(negedge clk);
    end
    chk("lat_sum_q", 32'(sq1), 32'd0);
    chk("lat_carry_q", 32'(cq1), 32'd1);
    chk("lat_cnt", 32'(cnt1), 32'd1);

    // a=b=1 held: 3-bit counter climbs to 7 and stays there.
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("sat_cnt_%0d", k), 32'(cnt1), (k > 7) ? 32'd7 : 32'(k));
    end

    chk("idle_cnt4", 32'(cnt4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Lane-parallel 1-bit half adder: sum = a XOR b and carry = a AND b per lane, presented combinationally (zero latency).
- Also provides a registered copy of both outputs and a saturating carry-event counter for status/debug.
- Leaf arithmetic primitive, used inside larger adders and by datapath glue logic.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; every data port is WIDTH bits; legal range 1..64.
- CNT_W, 8, width of carry_cnt; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock for registered outputs and counter.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- sum  output  WIDTH  combinational a ^ b.
- carry  output  WIDTH  combinational a & b.
- sum_q  output  WIDTH  sum registered on clk.
- carry_q  output  WIDTH  carry registered on clk.
- carry_cnt  output  CNT_W  saturating count of cycles with any carry bit set.

Behaviour:
- Combinational path:
  - sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i] for every lane i.
  - No clock dependency and no reset gating: these outputs are valid while rst_n is low.
  - Truth table per lane (a,b -> sum,carry): 00->00, 01->10, 10->10, 11->01.
  - Lanes are fully independent; no carry ripples between lanes.
- Registered path:
  - On each rising clk with rst_n high: sum_q <= sum, carry_q <= carry.
  - Latency is exactly 1 cycle.
- Carry counter:
  - On each rising clk with rst_n high, if |carry is 1 and carry_cnt is not all-ones, carry_cnt increments by 1.
  - At all-ones it holds: saturating, never wraps.
  - It counts cycles, not lanes: several lanes carrying in the same cycle add only 1.
- Reset:
  - rst_n low immediately forces sum_q = 0, carry_q = 0, carry_cnt = 0, independent of clk.
  - Reset asserted mid-operation clears the registered state within the same timestep; the combinational outputs are unaffected.
  - On the first rising edge after rst_n deasserts, the registers capture the current inputs normally.
- X/unknown inputs propagate per standard logic semantics; no internal state beyond the registers above.

Decomposition:
- No shared package required; WIDTH and CNT_W are local parameters of the block.
- One natural sub-module: half_adder_cell, a purely combinational 1-bit cell (a, b -> sum, carry).
  - Instantiate it WIDTH times via a generate loop.
  - The top level adds the output registers and the saturating counter.

Test Plan:
- WIDTH=1, hold rst_n high and apply {a,b} = 0,1,2,3 at 10 ns steps -> sum,carry = 0,0 / 1,0 / 1,0 / 0,1; combinational outputs settle within the same step.
- Registered latency: apply a=1,b=1 one cycle before an edge -> carry_q=1, sum_q=0 one cycle after the inputs change, not before.
- Reset: run with carries until carry_cnt=5, then pulse rst_n low between clock edges -> sum_q, carry_q and carry_cnt go to 0 immediately; sum/carry keep tracking a,b throughout.
- Saturation: CNT_W=3, hold a=b=1 for 10 cycles -> carry_cnt reaches 7 and stays at 7.
- Multi-lane: WIDTH=4, a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000; carry_cnt increments by exactly 1 per cycle.
- No-carry cycles: a=4'b0101, b=4'b1010 for 5 cycles -> sum=4'b1111, carry=0, and carry_cnt is unchanged.
